// File: rtl/bus_pkg.sv
// ============================================================================
// Module : bus_pkg
// Brief  : Shared types and constants for the two-master bus arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY    = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    localparam int unsigned DEFAULT_TIMEOUT   = 255;
    localparam logic [15:0] DEFAULT_BERR_DATA = 16'hFFFF;

    localparam logic MASTER_CPU = 1'b0;
    localparam logic MASTER_DMA = 1'b1;

    // Index of a master -> one-hot grant vector.
    function automatic logic [1:0] owner_onehot(input logic idx);
        owner_onehot = idx ? 2'b10 : 2'b01;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_timeout.sv
// ============================================================================
// Module : bus_timeout
// Brief  : 8-bit transaction watchdog; expired flags the TIMEOUT-th enabled cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bus_timeout
    import bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [8:0] LIMIT = 9'(TIMEOUT);

    // r_count holds the number of enabled cycles already completed, so the
    // current cycle index is r_count + 1.
    logic [7:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            r_count <= 8'd0;
        end else if (enable && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign expired = enable && (({1'b0, r_count} + 9'd1) == LIMIT);

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
// Module : bus_arbiter
// Brief  : Round-robin two-master arbiter with lock and timeout bus-error.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned TIMEOUT   = DEFAULT_TIMEOUT,
    parameter logic [15:0] BERR_DATA = DEFAULT_BERR_DATA
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic [31:0] m0_addr,
    input  logic [15:0] m0_write,
    output logic [15:0] m0_read,
    input  logic        m0_uds,
    input  logic        m0_lds,
    input  logic        m0_rw,
    input  logic        m0_lock,
    output logic        m0_ack,
    output logic        m0_berr,

    input  logic [31:0] m1_addr,
    input  logic [15:0] m1_write,
    output logic [15:0] m1_read,
    input  logic        m1_uds,
    input  logic        m1_lds,
    input  logic        m1_rw,
    input  logic        m1_lock,
    output logic        m1_ack,
    output logic        m1_berr,

    output logic [31:0] s_addr,
    output logic [15:0] s_write,
    output logic        s_rw,
    output logic        s_uds,
    output logic        s_lds,
    input  logic [15:0] s_read,
    input  logic        s_ack,

    output logic [1:0]  grant
);

    arb_state_t  r_state;
    arb_state_t  w_state_next;
    logic        r_owner;
    logic        w_owner_next;
    logic        r_last;
    logic        w_last_next;
    logic        r_lock_hold;
    logic        w_lock_next;

    logic [1:0]  w_req;
    logic        w_g_req;
    logic        w_g_lock;
    logic [31:0] w_g_addr;
    logic [15:0] w_g_write;
    logic        w_g_rw;
    logic        w_g_uds;
    logic        w_g_lds;

    logic        w_done;
    logic        w_berr;
    logic [15:0] w_read_data;
    logic        w_expired;
    logic        w_busy;
    logic        w_active;

    assign w_req     = {m1_uds | m1_lds, m0_uds | m0_lds};
    assign w_g_req   = w_req[r_owner];
    assign w_g_lock  = r_owner ? m1_lock  : m0_lock;
    assign w_g_addr  = r_owner ? m1_addr  : m0_addr;
    assign w_g_write = r_owner ? m1_write : m0_write;
    assign w_g_rw    = r_owner ? m1_rw    : m0_rw;
    assign w_g_uds   = r_owner ? m1_uds   : m0_uds;
    assign w_g_lds   = r_owner ? m1_lds   : m0_lds;

    assign w_busy   = (r_state == ARB_BUSY);
    assign w_active = (r_state != ARB_IDLE);

    bus_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!w_busy),
        .enable  (w_busy),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ARB_IDLE;
            r_owner     <= MASTER_CPU;
            r_last      <= MASTER_DMA;
            r_lock_hold <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_owner     <= w_owner_next;
            r_last      <= w_last_next;
            r_lock_hold <= w_lock_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        w_last_next  = r_last;
        w_lock_next  = r_lock_hold;
        w_done       = 1'b0;
        w_berr       = 1'b0;
        w_read_data  = 16'h0000;

        case (r_state)
            ARB_IDLE: begin
                // A held lock admits only the master that last completed.
                if (r_lock_hold) begin
                    if (w_req[r_last]) begin
                        w_owner_next = r_last;
                        w_state_next = ARB_BUSY;
                    end
                end else if (&w_req) begin
                    w_owner_next = ~r_last;
                    w_state_next = ARB_BUSY;
                end else if (w_req[0]) begin
                    w_owner_next = MASTER_CPU;
                    w_state_next = ARB_BUSY;
                end else if (w_req[1]) begin
                    w_owner_next = MASTER_DMA;
                    w_state_next = ARB_BUSY;
                end
            end

            ARB_BUSY: begin
                // A master withdrawing its strobes ends the transaction silently.
                if (!w_g_req) begin
                    w_state_next = ARB_IDLE;
                end else if (s_ack) begin
                    w_done       = 1'b1;
                    w_read_data  = s_read;
                    w_last_next  = r_owner;
                    w_lock_next  = w_g_lock;
                    w_state_next = ARB_RELEASE;
                end else if (w_expired) begin
                    w_done       = 1'b1;
                    w_berr       = 1'b1;
                    w_read_data  = BERR_DATA;
                    w_last_next  = r_owner;
                    w_lock_next  = 1'b0;
                    w_state_next = ARB_RELEASE;
                end
            end

            ARB_RELEASE: begin
                w_state_next = ARB_IDLE;
            end

            default: begin
                w_state_next = ARB_IDLE;
            end
        endcase
    end

    assign grant   = w_active ? owner_onehot(r_owner) : 2'b00;

    assign s_addr  = w_active ? w_g_addr  : 32'h0;
    assign s_write = w_active ? w_g_write : 16'h0;
    assign s_rw    = w_active & w_g_rw;
    assign s_uds   = w_busy & w_g_uds;
    assign s_lds   = w_busy & w_g_lds;

    assign m0_ack  = w_done & (r_owner == MASTER_CPU);
    assign m0_berr = w_berr & (r_owner == MASTER_CPU);
    assign m0_read = m0_ack ? w_read_data : 16'h0000;

    assign m1_ack  = w_done & (r_owner == MASTER_DMA);
    assign m1_berr = w_berr & (r_owner == MASTER_DMA);
    assign m1_read = m1_ack ? w_read_data : 16'h0000;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// Module : tb_bus_arbiter
// Brief  : Directed self-checking bench for bus_arbiter (TIMEOUT = 16).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] m0_addr, m1_addr;
    logic [15:0] m0_write, m1_write;
    logic [15:0] m0_read, m1_read;
    logic        m0_uds, m0_lds, m0_rw, m0_lock, m0_ack, m0_berr;
    logic        m1_uds, m1_lds, m1_rw, m1_lock, m1_ack, m1_berr;
    logic [31:0] s_addr;
    logic [15:0] s_write, s_read;
    logic        s_rw, s_uds, s_lds, s_ack;
    logic [1:0]  grant;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    bus_arbiter #(
        .TIMEOUT   (16),
        .BERR_DATA (16'hFFFF)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .m0_addr  (m0_addr),
        .m0_write (m0_write),
        .m0_read  (m0_read),
        .m0_uds   (m0_uds),
        .m0_lds   (m0_lds),
        .m0_rw    (m0_rw),
        .m0_lock  (m0_lock),
        .m0_ack   (m0_ack),
        .m0_berr  (m0_berr),
        .m1_addr  (m1_addr),
        .m1_write (m1_write),
        .m1_read  (m1_read),
        .m1_uds   (m1_uds),
        .m1_lds   (m1_lds),
        .m1_rw    (m1_rw),
        .m1_lock  (m1_lock),
        .m1_ack   (m1_ack),
        .m1_berr  (m1_berr),
        .s_addr   (s_addr),
        .s_write  (s_write),
        .s_rw     (s_rw),
        .s_uds    (s_uds),
        .s_lds    (s_lds),
        .s_read   (s_read),
        .s_ack    (s_ack),
        .grant    (grant)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        m0_addr  = '0; m0_write = '0; m0_uds = 1'b0; m0_lds = 1'b0; m0_rw = 1'b0; m0_lock = 1'b0;
        m1_addr  = '0; m1_write = '0; m1_uds = 1'b0; m1_lds = 1'b0; m1_rw = 1'b0; m1_lock = 1'b0;
        s_read   = '0; s_ack = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        logic [1:0] exp_g;

        // Reset state
        do_reset();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_s_uds", 32'(s_uds), 32'h0);
        check("rst_s_lds", 32'(s_lds), 32'h0);
        check("rst_m0_ack", 32'(m0_ack), 32'h0);
        check("rst_m1_ack", 32'(m1_ack), 32'h0);
        check("rst_s_addr", s_addr, 32'h0);
        reset_n = 1'b1;

        // m0 read of $000400, slave acks in the third BUSY cycle
        m0_addr = 32'h0000_0400; m0_rw = 1'b1; m0_uds = 1'b1; m0_lds = 1'b1;
        #1;
        check("t1_idle_grant", 32'(grant), 32'h0);
        tick();
        check("t1_busy_grant", 32'(grant), 32'h1);
        check("t1_s_addr", s_addr, 32'h0000_0400);
        check("t1_s_uds", 32'(s_uds), 32'h1);
        check("t1_s_rw", 32'(s_rw), 32'h1);
        check("t1_no_early_ack", 32'(m0_ack), 32'h0);
        tick();
        tick();
        s_ack = 1'b1; s_read = 16'h4E71;
        #1;
        check("t1_m0_ack", 32'(m0_ack), 32'h1);
        check("t1_m0_read", 32'(m0_read), 32'h4E71);
        check("t1_m0_berr", 32'(m0_berr), 32'h0);
        check("t1_m1_ack", 32'(m1_ack), 32'h0);
        check("t1_m1_read", 32'(m1_read), 32'h0);
        tick();
        s_ack = 1'b0; m0_uds = 1'b0; m0_lds = 1'b0;
        #1;
        check("t1_rel_grant", 32'(grant), 32'h1);
        check("t1_rel_s_uds", 32'(s_uds), 32'h0);
        check("t1_rel_ack", 32'(m0_ack), 32'h0);
        tick();
        check("t1_idle_after", 32'(grant), 32'h0);

        // Both masters write continuously from reset: 01,10,01,10
        do_reset();
        reset_n = 1'b1;
        m0_addr = 32'h100; m0_write = 16'h1111; m0_rw = 1'b0; m0_uds = 1'b1;
        m1_addr = 32'h200; m1_write = 16'h2222; m1_rw = 1'b0; m1_lds = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            check("rr_grant", 32'(grant), 32'(exp_g));
            check("rr_s_write", 32'(s_write), (exp_g == 2'b01) ? 32'h1111 : 32'h2222);
            s_ack = 1'b1;
            #1;
            check("rr_m0_ack", 32'(m0_ack), (exp_g == 2'b01) ? 32'h1 : 32'h0);
            check("rr_m1_ack", 32'(m1_ack), (exp_g == 2'b10) ? 32'h1 : 32'h0);
            tick();
            s_ack = 1'b0;
            #1;
            check("rr_rel_grant", 32'(grant), 32'(exp_g));
            tick();
            check("rr_idle_grant", 32'(grant), 32'h0);
        end
        m0_uds = 1'b0; m1_lds = 1'b0;

        // m1 read of an unmapped address never acked: bus error in BUSY cycle 16
        do_reset();
        reset_n = 1'b1;
        m1_addr = 32'h00FF_F000; m1_rw = 1'b1; m1_lds = 1'b1;
        tick();
        for (int c = 1; c < 16; c++) begin
            check("to_no_early_ack", 32'(m1_ack), 32'h0);
            tick();
        end
        check("to_m1_ack", 32'(m1_ack), 32'h1);
        check("to_m1_berr", 32'(m1_berr), 32'h1);
        check("to_m1_read", 32'(m1_read), 32'hFFFF);
        check("to_grant", 32'(grant), 32'h2);
        tick();
        m1_lds = 1'b0;
        #1;
        check("to_rel_ack", 32'(m1_ack), 32'h0);
        check("to_rel_berr", 32'(m1_berr), 32'h0);
        tick();

        // Locked read by m0 keeps the bus for its write; m1 waits one extra turn
        m0_addr = 32'h300; m0_rw = 1'b1; m0_uds = 1'b1; m0_lds = 1'b1; m0_lock = 1'b1;
        m1_addr = 32'h400; m1_rw = 1'b0; m1_lds = 1'b1; m1_write = 16'h5555;
        tick();
        check("lk_first_grant", 32'(grant), 32'h1);
        s_ack = 1'b1; s_read = 16'h00FF;
        #1;
        check("lk_read_ack", 32'(m0_ack), 32'h1);
        tick();
        s_ack = 1'b0; m0_rw = 1'b0; m0_write = 16'h80FF; m0_lock = 1'b0;
        tick();
        check("lk_idle_grant", 32'(grant), 32'h0);
        tick();
        check("lk_regrant", 32'(grant), 32'h1);
        check("lk_s_write", 32'(s_write), 32'h80FF);
        check("lk_s_rw", 32'(s_rw), 32'h0);
        s_ack = 1'b1;
        #1;
        check("lk_write_ack", 32'(m0_ack), 32'h1);
        tick();
        s_ack = 1'b0; m0_uds = 1'b0; m0_lds = 1'b0;
        tick();
        tick();
        check("lk_m1_grant", 32'(grant), 32'h2);
        s_ack = 1'b1;
        #1;
        check("lk_m1_ack", 32'(m1_ack), 32'h1);
        tick();
        s_ack = 1'b0; m1_lds = 1'b0;
        tick();

        // m0 withdraws mid-BUSY: no ack, IDLE, then the pending m1 is served
        m0_addr = 32'h500; m0_rw = 1'b1; m0_uds = 1'b1;
        m1_addr = 32'h600; m1_rw = 1'b1; m1_lds = 1'b1;
        tick();
        check("ab_grant", 32'(grant), 32'h1);
        tick();
        m0_uds = 1'b0; m0_lds = 1'b0;
        #1;
        check("ab_no_ack", 32'(m0_ack), 32'h0);
        check("ab_s_uds", 32'(s_uds), 32'h0);
        tick();
        check("ab_idle_grant", 32'(grant), 32'h0);
        tick();
        check("ab_m1_grant", 32'(grant), 32'h2);
        check("ab_s_addr", s_addr, 32'h600);

        // Reset asserted while m1 is in BUSY
        reset_n = 1'b0;
        tick();
        check("rb_grant", 32'(grant), 32'h0);
        check("rb_m1_ack", 32'(m1_ack), 32'h0);
        check("rb_s_lds", 32'(s_lds), 32'h0);
        check("rb_s_addr", s_addr, 32'h0);
        reset_n = 1'b1;
        m1_lds = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter placed between the bus masters and the `device_mux` master port, so the TG68 CPU (master 0) and a DMA engine (master 1) share the slave bus (boot_device, uart, leds_dev, spi). Grants one 16-bit transaction at a time with round-robin fairness, optional lock for read-modify-write sequences, and a watchdog that terminates transactions nobody acknowledges with a bus-error flag.

## Interface
Parameters:
- `TIMEOUT`, 255: BUSY cycles without `s_ack` before forced termination (1..255).
- `BERR_DATA`, 16'hFFFF: read data returned on timeout.

Ports (N = 0, 1):
- `clk`  in  1  system clock; sole clock.
- `reset_n`  in  1  reset, synchronous, active-low.
- `mN_addr`  in  32  requester byte address.
- `mN_write`  in  16  requester write data.
- `mN_read`  out  16  read data to requester.
- `mN_uds` / `mN_lds`  in  1  active-high byte strobes; either high = request.
- `mN_rw`  in  1  1 = read, 0 = write.
- `mN_lock`  in  1  keep grant for the next transaction.
- `mN_ack`  out  1  one-cycle completion pulse.
- `mN_berr`  out  1  high with `mN_ack` when terminated by timeout.
- `s_addr`  out  32, `s_write` out 16, `s_rw` out 1: forwarded from granted master.
- `s_uds` / `s_lds`  out  1  forwarded strobes, active-high.
- `s_read`  in  16, `s_ack` in 1: from `device_mux`.
- `grant`  out  2  one-hot current owner; 2'b00 when idle.

## Operation
- States: IDLE, BUSY, RELEASE; `last` register records last served master.
- IDLE: if one master requests, grant it; if both, grant the master != `last`; if `lock_hold` set, only the locked master may be granted (other waits). Next state BUSY.
- BUSY: `s_addr/s_write/s_rw/s_uds/s_lds` combinationally follow the granted master's inputs; timeout counter increments each cycle.
  - `s_ack`=1: granted `mN_ack`=1, `mN_read`=`s_read`, `berr`=0; `last`<=grant; `lock_hold`<=granted `mN_lock`; next RELEASE.
  - counter reaches `TIMEOUT` with no `s_ack`: `mN_ack`=1, `mN_berr`=1, `mN_read`=`BERR_DATA`; `last`<=grant; `lock_hold`<=0; next RELEASE.
  - granted master drops both strobes before ack: abort, no ack, `last` unchanged, next IDLE.
  - `s_ack` and timeout same cycle: ack wins, `berr`=0.
- RELEASE: all `s_*` strobes 0, `grant` held, one cycle, then IDLE (lets the master drop its strobes).
- Non-granted master: `mN_ack`=0, `mN_berr`=0, `mN_read`=16'h0000. `s_ack` outside BUSY is ignored.
- `s_*` address/data lines are 0 when no grant.

## Timing
- Reset (next edge with `reset_n`=0, at any state): state IDLE, `grant`=00, `s_uds`=`s_lds`=0, all acks/berr 0, counter 0, `lock_hold`=0, `last`=1 (CPU wins first tie). An in-flight transaction is dropped without ack.
- Request seen in cycle 0 (IDLE) -> strobes on `s_*` in cycle 1 -> earliest ack in cycle 1 (ack and read data combinational from `s_ack`/`s_read`) -> RELEASE cycle 2 -> IDLE cycle 3. Minimum 3 cycles per transaction.
- Timeout: with no `s_ack`, `mN_ack`+`berr` asserts in BUSY cycle `TIMEOUT` (counter 1..TIMEOUT, cleared on leaving BUSY).
- Round-robin: with both masters requesting continuously, grants alternate 0,1,0,1; no master waits more than one transaction, except behind a lock chain.

## Structure
- Shared package `bus_pkg`: state encoding (ARB_IDLE, ARB_BUSY, ARB_RELEASE), `TIMEOUT` default, `BERR_DATA`, master index constants (MASTER_CPU=0, MASTER_DMA=1).
- Sub-module `bus_timeout`: 8-bit counter with clear/enable, `expired` output at `TIMEOUT`.
- Top contains the FSM, `last`/`lock_hold` registers and the output muxes.

## Test plan
- Reset, then m0 read $000400 with slave ack 2 cycles later, `s_read`=16'h4E71 -> `m0_ack` one cycle, `m0_read`=4E71, `grant` 01->00 after RELEASE.
- m0 and m1 request writes in the same IDLE cycle after reset -> m0 served first, then m1; repeat continuously -> grants alternate 01,10,01,10.
- m1 read to an unmapped address, `s_ack` never asserts, `TIMEOUT`=16 -> `m1_ack`=`m1_berr`=1 in BUSY cycle 16, `m1_read`=FFFF.
- m0 `lock`=1 on a read while m1 requests -> next grant is m0 again (write of the TAS), m1 granted only after the unlocked m0 transaction.
- m0 drops strobes mid-BUSY -> no ack, IDLE next cycle, pending m1 granted; `reset_n` low during BUSY -> all outputs at reset values next edge, no ack.
